// File: rtl/aes_pkg.sv
// Shared AES definitions: controller state encoding, round count and the
// ShiftRows byte permutation used by the round datapath.
package aes_pkg;

   localparam int AES_NR = 10;

   typedef enum logic [2:0] {
      IDLE,
      KEY0,
      SUB,
      MIX,
      OUT
   } aes_state_e;

   // Output byte 4c+r takes input byte 4*((c+r) mod 4)+r.
   function automatic int sr_src(input int k);
      return 4 * (((k / 4) + (k % 4)) % 4) + (k % 4);
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int k = 0; k < 16; k++) begin
         r[8*k +: 8] = s[8*sr_src(k) +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/aes_mixcolumns.sv
// Combinational AES MixColumns over all four columns of a 128-bit state;
// byte 4c+r is row r of column c.
module aes_mixcolumns (
   input  logic [127:0] state,
   output logic [127:0] mixed
);

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] a0, a1, a2, a3;

      assign a0 = state[32*c      +: 8];
      assign a1 = state[32*c + 8  +: 8];
      assign a2 = state[32*c + 16 +: 8];
      assign a3 = state[32*c + 24 +: 8];

      // {02}x is xtime(x); {03}x is xtime(x) ^ x.
      assign mixed[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign mixed[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign mixed[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign mixed[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
   end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 encryption round controller: iterates rounds over a 128-bit state,
// borrowing a shared 32-bit S-box one column per cycle and fetching round keys.
module aes_round_ctrl
   import aes_pkg::*;
#(
   parameter int NR = AES_NR
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_block,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_block,
   output logic         rk_req,
   output logic [3:0]   rk_idx,
   input  logic         rk_valid,
   input  logic [127:0] rk_data,
   output logic [31:0]  sb_in,
   input  logic [31:0]  sb_out,
   output logic         busy
);

   aes_state_e   fsm;
   logic [127:0] state;
   logic [3:0]   round_cnt;
   logic [1:0]   col_cnt;
   logic [127:0] shifted;
   logic [127:0] mixed;
   logic [31:0]  column;

   assign shifted = shift_rows(state);

   aes_mixcolumns u_mix (
      .state (shifted),
      .mixed (mixed)
   );

   assign column = state[{col_cnt, 5'b0} +: 32];

   // All outputs decode registered state only, so none depend on inputs.
   assign in_ready  = (fsm == IDLE);
   assign out_valid = (fsm == OUT);
   assign busy      = (fsm != IDLE);
   assign rk_req    = (fsm == KEY0) || (fsm == MIX);
   assign rk_idx    = rk_req ? round_cnt : 4'd0;
   assign sb_in     = (fsm == SUB) ? column : 32'd0;
   assign out_block = state;

   // The last round skips MixColumns and leaves the ciphertext in state.
   always_ff @(posedge clk) begin
      if (reset) begin
         fsm       <= IDLE;
         state     <= '0;
         round_cnt <= '0;
         col_cnt   <= '0;
      end else begin
         case (fsm)
            IDLE: begin
               if (in_valid) begin
                  state     <= in_block;
                  round_cnt <= '0;
                  col_cnt   <= '0;
                  fsm       <= KEY0;
               end
            end
            KEY0: begin
               if (rk_valid) begin
                  state     <= state ^ rk_data;
                  round_cnt <= 4'd1;
                  col_cnt   <= '0;
                  fsm       <= SUB;
               end
            end
            SUB: begin
               state[{col_cnt, 5'b0} +: 32] <= sb_out;
               col_cnt <= col_cnt + 2'd1;
               if (col_cnt == 2'd3) begin
                  fsm <= MIX;
               end
            end
            MIX: begin
               if (rk_valid) begin
                  if (round_cnt == 4'(NR)) begin
                     state <= shifted ^ rk_data;
                     fsm   <= OUT;
                  end else begin
                     state     <= mixed ^ rk_data;
                     round_cnt <= round_cnt + 4'd1;
                     col_cnt   <= '0;
                     fsm       <= SUB;
                  end
               end
            end
            OUT: begin
               if (out_ready) begin
                  fsm <= IDLE;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule
